// File: rtl/ftdi_route_ctrl.sv
// rtl/ftdi_route_ctrl.sv - FTDI receive-stream packet steering to IQ FIFO or ECPU
module ftdi_route_ctrl #(
  parameter int           IQ_DATA_WIDTH = 24,
  parameter logic [7:0]   HDR_SYNC      = 8'hA5,
  parameter int           CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic [IQ_DATA_WIDTH-1:0] f2a_data_i,
  input  logic                     f2a_we_i,
  input  logic                     fifo_full_i,
  input  logic                     cpu_busy_i,
  input  logic                     err_clr_i,
  output logic [IQ_DATA_WIDTH-1:0] f2a_data_o,
  output logic                     f2a_we_o,
  output logic [IQ_DATA_WIDTH-1:0] f2cpu_data_o,
  output logic                     f2cpu_we_o,
  output logic                     busy_o,
  output logic                     dest_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o,
  output logic                     err_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  logic [0:0] state;
  logic [7:0] remaining;

  logic word_valid;
  logic sync_hit;
  logic rsv_zero;
  logic hdr_ok;
  logic dest_ready;
  logic drop_evt;
  logic err_evt;

  assign word_valid = en_i && f2a_we_i;
  assign sync_hit   = (f2a_data_i[IQ_DATA_WIDTH-1 -: 8] == HDR_SYNC);
  assign rsv_zero   = (f2a_data_i[15:9] == 7'd0);
  assign hdr_ok     = sync_hit && rsv_zero;
  assign dest_ready = dest_o ? !cpu_busy_i : !fifo_full_i;
  assign busy_o     = (state == ST_PAYLOAD);

  // Every word that is neither a good header nor a delivered payload word is a drop;
  // only a corrupt header or an undeliverable payload word is an error.
  always_comb begin
    drop_evt = 1'b0;
    err_evt  = 1'b0;
    if (word_valid) begin
      if (state == ST_IDLE) begin
        drop_evt = !hdr_ok;
        err_evt  = sync_hit && !rsv_zero;
      end else begin
        drop_evt = !dest_ready;
        err_evt  = !dest_ready;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      remaining <= 8'd0;
      dest_o    <= 1'b0;
    end else if (!en_i) begin
      state     <= ST_IDLE;
      remaining <= 8'd0;
    end else if (f2a_we_i) begin
      if (state == ST_IDLE) begin
        if (hdr_ok) begin
          dest_o    <= f2a_data_i[8];
          remaining <= f2a_data_i[7:0];
          state     <= (f2a_data_i[7:0] != 8'd0) ? ST_PAYLOAD : ST_IDLE;
        end
      end else begin
        remaining <= remaining - 8'd1;
        if (remaining == 8'd1) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  // Data registers hold between strobes so downstream may sample them late.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      f2a_we_o     <= 1'b0;
      f2cpu_we_o   <= 1'b0;
      f2a_data_o   <= '0;
      f2cpu_data_o <= '0;
    end else begin
      f2a_we_o   <= 1'b0;
      f2cpu_we_o <= 1'b0;
      if (word_valid && (state == ST_PAYLOAD) && dest_ready) begin
        if (dest_o) begin
          f2cpu_we_o   <= 1'b1;
          f2cpu_data_o <= f2a_data_i;
        end else begin
          f2a_we_o   <= 1'b1;
          f2a_data_o <= f2a_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (drop_evt && (drop_cnt_o != {CNT_WIDTH{1'b1}})) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end
      if (err_evt) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ftdi_route_ctrl.sv
// tb/tb_ftdi_route_ctrl.sv - self-checking bench for ftdi_route_ctrl
module tb_ftdi_route_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] din;
  logic        we;
  logic        full;
  logic        cbusy;
  logic        clr;

  logic [23:0] fdata, cdata, fdata4, cdata4;
  logic        fwe, cwe, busy, dest, err;
  logic        fwe4, cwe4, busy4, dest4, err4;
  logic [15:0] drop;
  logic [3:0]  drop4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ftdi_route_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .f2a_data_i(din), .f2a_we_i(we),
    .fifo_full_i(full), .cpu_busy_i(cbusy), .err_clr_i(clr),
    .f2a_data_o(fdata), .f2a_we_o(fwe), .f2cpu_data_o(cdata), .f2cpu_we_o(cwe),
    .busy_o(busy), .dest_o(dest), .drop_cnt_o(drop), .err_o(err)
  );

  ftdi_route_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .f2a_data_i(din), .f2a_we_i(we),
    .fifo_full_i(full), .cpu_busy_i(cbusy), .err_clr_i(clr),
    .f2a_data_o(fdata4), .f2a_we_o(fwe4), .f2cpu_data_o(cdata4), .f2cpu_we_o(cwe4),
    .busy_o(busy4), .dest_o(dest4), .drop_cnt_o(drop4), .err_o(err4)
  );

  // Reference model: packet bookkeeping as plain integers.
  int          m_left;
  bit          m_dest;
  int          m_drops;
  bit          m_err;
  bit          m_fwe, m_cwe;
  logic [23:0] m_fdata, m_cdata;

  task automatic model_reset();
    m_left = 0; m_dest = 0; m_drops = 0; m_err = 0;
    m_fwe = 0; m_cwe = 0; m_fdata = '0; m_cdata = '0;
  endtask

  task automatic model_step(input bit i_en, input bit i_we, input bit i_full,
                            input bit i_cb, input bit i_clr, input logic [23:0] d);
    bit dropped = 0;
    bit bad = 0;
    m_fwe = 0;
    m_cwe = 0;
    if (!i_en) begin
      m_left = 0;
    end else if (i_we) begin
      if (m_left == 0) begin
        if (d[23:16] == 8'hA5 && d[15:9] == 7'd0) begin
          m_dest = d[8];
          m_left = int'(d[7:0]);
        end else begin
          dropped = 1;
          bad = (d[23:16] == 8'hA5);
        end
      end else begin
        m_left = m_left - 1;
        if (m_dest ? i_cb : i_full) begin
          dropped = 1;
          bad = 1;
        end else if (m_dest) begin
          m_cwe = 1; m_cdata = d;
        end else begin
          m_fwe = 1; m_fdata = d;
        end
      end
    end
    if (dropped) m_drops = m_drops + 1;
    if (bad) m_err = 1;
    else if (i_clr) m_err = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " f2a_we"},   32'(fwe),   32'(m_fwe));
    chk({tag, " f2cpu_we"}, 32'(cwe),   32'(m_cwe));
    chk({tag, " f2a_data"}, 32'(fdata), 32'(m_fdata));
    chk({tag, " f2cpu_data"}, 32'(cdata), 32'(m_cdata));
    chk({tag, " busy"},     32'(busy),  32'(m_left != 0));
    chk({tag, " dest"},     32'(dest),  32'(m_dest));
    chk({tag, " err"},      32'(err),   32'(m_err));
    chk({tag, " drop16"},   32'(drop),  32'((m_drops > 65535) ? 65535 : m_drops));
    chk({tag, " drop4"},    32'(drop4), 32'((m_drops > 15) ? 15 : m_drops));
  endtask

  // Drive at the falling edge, advance through the rising edge, sample at the next falling edge.
  task automatic step(input bit i_en, input bit i_we, input bit i_full, input bit i_cb,
                      input bit i_clr, input logic [23:0] d);
    en = i_en; we = i_we; full = i_full; cbusy = i_cb; clr = i_clr; din = d;
    @(posedge clk);
    model_step(i_en, i_we, i_full, i_cb, i_clr, d);
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  ctl;     // en, we, full, cbusy, clr
    logic [23:0] data;
    logic [4:0]  eflg;    // fifo_we, cpu_we, busy, dest, err
    logic [23:0] edata;
    int          edrop;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{5'b11000, 24'hA50003, 5'b00100, 24'h000000, 0};
    tbl[1]  = '{5'b11000, 24'h111111, 5'b10100, 24'h111111, 0};
    tbl[2]  = '{5'b11000, 24'h222222, 5'b10100, 24'h222222, 0};
    tbl[3]  = '{5'b11000, 24'h333333, 5'b10000, 24'h333333, 0};
    tbl[4]  = '{5'b10000, 24'h000000, 5'b00000, 24'h000000, 0};
    tbl[5]  = '{5'b11000, 24'hA50102, 5'b00110, 24'h000000, 0};
    tbl[6]  = '{5'b11000, 24'hA50000, 5'b01110, 24'hA50000, 0};
    tbl[7]  = '{5'b11000, 24'h000001, 5'b01010, 24'h000001, 0};
    tbl[8]  = '{5'b11000, 24'h123456, 5'b00010, 24'h000000, 1};
    tbl[9]  = '{5'b11000, 24'h123456, 5'b00010, 24'h000000, 2};
    tbl[10] = '{5'b11000, 24'hA50200, 5'b00011, 24'h000000, 3};
    tbl[11] = '{5'b10001, 24'h000000, 5'b00010, 24'h000000, 3};
    tbl[12] = '{5'b11000, 24'hA50004, 5'b00100, 24'h000000, 3};
    tbl[13] = '{5'b11000, 24'h000010, 5'b10100, 24'h000010, 3};
    tbl[14] = '{5'b11100, 24'h000020, 5'b00101, 24'h000000, 4};
    tbl[15] = '{5'b11000, 24'h000030, 5'b10101, 24'h000030, 4};
    tbl[16] = '{5'b11000, 24'h000040, 5'b10001, 24'h000040, 4};

    rst_n = 1'b0; en = 0; we = 0; full = 0; cbusy = 0; clr = 0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset f2a_we", 32'(fwe), 0);
    chk("reset f2cpu_we", 32'(cwe), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset dest", 32'(dest), 0);
    chk("reset drop", 32'(drop), 0);
    chk("reset err", 32'(err), 0);
    chk("reset f2a_data", 32'(fdata), 0);
    chk("reset f2cpu_data", 32'(cdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: header/forwarding, ECPU path, garbage and corrupt header, FIFO backpressure.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].ctl[4], tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].data);
      chk($sformatf("tbl%0d f2a_we", i),   32'(fwe),  32'(tbl[i].eflg[4]));
      chk($sformatf("tbl%0d f2cpu_we", i), 32'(cwe),  32'(tbl[i].eflg[3]));
      chk($sformatf("tbl%0d busy", i),     32'(busy), 32'(tbl[i].eflg[2]));
      chk($sformatf("tbl%0d dest", i),     32'(dest), 32'(tbl[i].eflg[1]));
      chk($sformatf("tbl%0d err", i),      32'(err),  32'(tbl[i].eflg[0]));
      chk($sformatf("tbl%0d drop", i),     32'(drop), 32'(tbl[i].edrop));
      if (tbl[i].eflg[4]) chk($sformatf("tbl%0d f2a_data", i), 32'(fdata), 32'(tbl[i].edata));
      if (tbl[i].eflg[3]) chk($sformatf("tbl%0d f2cpu_data", i), 32'(cdata), 32'(tbl[i].edata));
    end

    // Enable drop mid-packet aborts it; later words are parsed fresh and dropped.
    step(1, 1, 0, 0, 0, 24'hA50005); check_model("t5 hdr");
    step(1, 1, 0, 0, 0, 24'h0000AA); check_model("t5 w1");
    step(1, 1, 0, 0, 0, 24'h0000BB); check_model("t5 w2");
    step(0, 1, 0, 0, 0, 24'h0000CC); check_model("t5 en_low");
    chk("t5 busy after en low", 32'(busy), 0);
    chk("t5 en low no count", 32'(drop), 4);
    step(1, 0, 0, 0, 0, 24'h000000); check_model("t5 idle");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 24'h000000);
      check_model($sformatf("t5 zero%0d", i));
    end
    chk("t5 drop +3", 32'(drop), 7);
    chk("t5 busy", 32'(busy), 0);

    // Saturation of the narrow counter.
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0, 24'h123456);
      check_model($sformatf("t6 sat%0d", i));
    end
    chk("t6 drop4 saturated", 32'(drop4), 32'h0000000F);
    chk("t6 drop16", 32'(drop), 17);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [23:0] d;
      int r;
      d = 24'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 30) begin
        d[23:16] = 8'hA5;
        d[15:9]  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'd0;
        d[7:0]   = 8'($urandom_range(0, 6));
      end else if (r < 40) begin
        d[23:16] = 8'hA5;
      end
      step(($urandom_range(0, 99) >= 4), ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 8), d);
      check_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a packet.
    step(1, 1, 0, 0, 0, 24'hA50003);
    step(1, 1, 1, 0, 0, 24'h00ABCD);
    step(1, 1, 0, 0, 0, 24'h00BEEF);
    check_model("pre-reset");
    en = 1; we = 1; din = 24'h00CAFE; full = 0; cbusy = 0; clr = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async f2a_we", 32'(fwe), 0);
    chk("async f2cpu_we", 32'(cwe), 0);
    chk("async busy", 32'(busy), 0);
    chk("async dest", 32'(dest), 0);
    chk("async drop", 32'(drop), 0);
    chk("async drop4", 32'(drop4), 0);
    chk("async err", 32'(err), 0);
    chk("async f2a_data", 32'(fdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, 24'h00F00D);
    check_model("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
